mem_load_sequencer: RTL and testbench
=====================================

MEM_LOAD_SEQUENCER -- requirements
Module: mem_load_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: consecutive hit=0 cycles on one byte before a load aborts.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port req, input, 1: load request from the pipeline, sampled only in IDLE.
REQ-005 SHALL have port addr, input, 32: byte address of the load.
REQ-006 SHALL have port size, input, 2: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have port signExt, input, 1: sign-extend byte/half results when 1.
REQ-008 SHALL have port memAddress, output, 32: registered byte address to byte-wide data memory.
REQ-009 SHALL have port memReq, output, 1: registered; high while a byte is being requested.
REQ-010 SHALL have port hit, input, 1: memory response valid; sampled at posedge.
REQ-011 SHALL have port memOut, input, 8: memory byte; captured only when hit=1.
REQ-012 SHALL have port loadData, output, 32: assembled result; valid when done=1.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port error, output, 1: one-cycle timeout pulse.
REQ-015 SHALL have port busy, output, 1: high in any state but IDLE; pipeline stall.

Function
REQ-016 SHALL implement states IDLE, FETCH, DONE, ERR.
REQ-017 IDLE with req=1 SHALL latch addr/size/signExt, set N = 1/2/4 bytes, byte index i=0, memAddress=addr, memReq=1, go FETCH.
REQ-018 FETCH with hit=1 SHALL store memOut into bits [8i+7:8i] (little-endian); if i=N-1 go DONE with memReq=0, else i++, memAddress=addr+i+1.
REQ-019 FETCH with hit=0 SHALL hold memAddress and i and increment a wait counter; counter SHALL clear on every accepted byte.
REQ-020 On the edge where the wait counter would reach TIMEOUT, FETCH SHALL go ERR with memReq=0.
REQ-021 DONE SHALL drive done=1 and loadData for exactly one cycle, then go IDLE.
REQ-022 ERR SHALL drive error=1 and loadData=0 for exactly one cycle, then go IDLE.
REQ-023 Byte loads SHALL fill bits [31:8] with bit 7 if signExt=1, else zeros; half loads SHALL fill [31:16] with bit 15 or zeros.
REQ-024 Address increment SHALL wrap modulo 2^32; unaligned addresses SHALL be legal and serviced bytewise.
REQ-025 req in FETCH, DONE or ERR SHALL be ignored; no queuing.
REQ-026 With hit held 1, done SHALL assert in the cycle after edge k+N, where k is the accepting edge; the next req is accepted no earlier than edge k+N+2.
REQ-027 done and error SHALL never be high together; busy SHALL equal (state != IDLE).

Reset
REQ-028 reset=1 at a posedge SHALL force IDLE in that cycle, including mid-FETCH, discarding partial data.
REQ-029 After reset: memAddress=0, memReq=0, loadData=0, done=0, error=0, busy=0, all counters 0.
REQ-030 reset SHALL take priority over req and hit in the same cycle.

Verification
REQ-031 Word load, addr=0x100, hit always 1, memory returns addr[7:0] -> memAddress 0x100..0x103 on consecutive cycles, loadData=0x03020100, done 1 cycle, 4-cycle latency per REQ-026.
REQ-032 Byte load, addr=0x80, signExt=1, memOut=0x80 -> loadData=0xFFFFFF80; same with signExt=0 -> 0x00000080.
REQ-033 Half load, addr=0xFFFFFFFF, hit=1, memOut=addr[7:0] -> requests 0xFFFFFFFF then 0x00000000, loadData=0x000000FF (signExt=0).
REQ-034 Word load with hit=0 for 3 cycles before byte 2 -> memAddress held at addr+2 for those cycles, correct result, done 3 cycles later than REQ-031.
REQ-035 hit=0 for TIMEOUT cycles -> error pulse once, loadData=0, done never asserted, busy drops next cycle; reset asserted mid-FETCH -> all outputs zero next cycle, new req then accepted normally.

Source files
------------

// File: rtl/mem_load_sequencer.sv
// rtl/mem_load_sequencer.sv - byte-serial load sequencer
// Assembles 1/2/4-byte little-endian loads from a byte-wide memory with a miss timeout.
module mem_load_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] memAddress,
  output logic        memReq,
  input  logic        hit,
  input  logic [7:0]  memOut,
  output logic [31:0] loadData,
  output logic        done,
  output logic        error,
  output logic        busy
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  last_q;
  logic [1:0]  idx_q;
  logic [WW-1:0] wait_q;
  logic [31:0] data_q;
  logic [31:0] mem_addr_q;
  logic        mem_req_q;
  logic [31:0] load_data_q;
  logic        done_q;
  logic        error_q;

  logic [31:0] merged_d;
  logic [31:0] result_d;
  logic [1:0]  last_d;

  always_comb begin
    merged_d = data_q;
    merged_d[{idx_q, 3'b000} +: 8] = memOut;
  end

  // Extension is applied to the merged word so the final byte is included.
  always_comb begin
    result_d = merged_d;
    case (size_q)
      2'b00:   result_d = {{24{sext_q & merged_d[7]}}, merged_d[7:0]};
      2'b01:   result_d = {{16{sext_q & merged_d[15]}}, merged_d[15:0]};
      default: result_d = merged_d;
    endcase
  end

  always_comb begin
    case (size)
      2'b00:   last_d = 2'd0;
      2'b01:   last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
      wait_q      <= '0;
      data_q      <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_req_q   <= 1'b0;
      load_data_q <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          load_data_q <= 32'd0;
          if (req) begin
            size_q     <= size;
            sext_q     <= signExt;
            last_q     <= last_d;
            idx_q      <= 2'd0;
            wait_q     <= '0;
            data_q     <= 32'd0;
            mem_addr_q <= addr;
            mem_req_q  <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (hit) begin
            data_q <= merged_d;
            wait_q <= '0;
            if (idx_q == last_q) begin
              mem_req_q   <= 1'b0;
              load_data_q <= result_d;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idx_q      <= idx_q + 2'd1;
              mem_addr_q <= mem_addr_q + 32'd1;
            end
          end else if (wait_q == WW'(TIMEOUT - 1)) begin
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            load_data_q <= 32'd0;
            error_q     <= 1'b1;
            state_q     <= S_ERR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          load_data_q <= 32'd0;
          state_q     <= S_IDLE;
        end
        S_ERR: begin
          error_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign memAddress = mem_addr_q;
  assign memReq     = mem_req_q;
  assign loadData   = load_data_q;
  assign done       = done_q;
  assign error      = error_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_load_sequencer.sv
// tb/tb_mem_load_sequencer.sv - self-checking bench for mem_load_sequencer
// Bench plays the byte memory; expected data and latency come from the load rules.
module tb_mem_load_sequencer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, req, signExt, memReq, hit, done, error, busy;
  logic [31:0] addr, memAddress, loadData;
  logic [1:0]  size;
  logic [7:0]  memOut;
  logic [7:0]  key = 8'h00;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_load_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .size(size),
    .signExt(signExt), .memAddress(memAddress), .memReq(memReq), .hit(hit),
    .memOut(memOut), .loadData(loadData), .done(done), .error(error), .busy(busy)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ key;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ms[j] = hit=0 cycles before byte j; a value of TO means the load must time out.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                          input int m0, input int m1, input int m2, input int m3);
    int ms[4];
    int n, cyc, total;
    logic [31:0] expv, ea;
    logic [7:0] b;
    ms = '{m0, m1, m2, m3};
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    expv = 32'd0;
    cyc = 0;
    total = 0;
    req = 1'b1; addr = a; size = sz; signExt = sx; hit = 1'b0; memOut = 8'($urandom);
    step();
    chk1("accept_busy", busy, 1'b1);
    chk1("accept_memreq", memReq, 1'b1);
    chk32("accept_addr", memAddress, a);
    addr = $urandom; size = 2'($urandom); signExt = 1'($urandom);
    for (int j = 0; j < n; j++) begin
      ea = a + 32'(j);
      for (int m = 0; m < ms[j]; m++) begin
        hit = 1'b0; memOut = 8'($urandom);
        step();
        cyc++;
        if (m + 1 == TO) begin
          chk1("err_pulse", error, 1'b1);
          chk32("err_data", loadData, 32'd0);
          chk1("err_nodone", done, 1'b0);
          chk1("err_memreq", memReq, 1'b0);
          step();
          chk1("err_once", error, 1'b0);
          chk1("err_idle", busy, 1'b0);
          req = 1'b0;
          return;
        end
        chk32("hold_addr", memAddress, ea);
        chk1("hold_nodone", done, 1'b0);
      end
      total += ms[j];
      hit = 1'b1;
      b = mem_byte(ea);
      memOut = b;
      expv[8*j +: 8] = b;
      step();
      cyc++;
      if (j < n - 1) begin
        chk32("next_addr", memAddress, ea + 32'd1);
        chk1("next_memreq", memReq, 1'b1);
      end
    end
    hit = 1'b0;
    if (sz == 2'b00) expv = sx ? 32'($signed(expv[7:0])) : 32'(expv[7:0]);
    else if (sz == 2'b01) expv = sx ? 32'($signed(expv[15:0])) : 32'(expv[15:0]);
    chk1("done_pulse", done, 1'b1);
    chk32("load_data", loadData, expv);
    chk1("done_noerr", error, 1'b0);
    chk1("done_memreq", memReq, 1'b0);
    chk32("latency", 32'(cyc), 32'(n + total));
    step();
    chk1("done_once", done, 1'b0);
    chk1("back_idle", busy, 1'b0);
    req = 1'b0;
  endtask

  initial begin
    int ms[4];
    reset = 1'b1; req = 1'b0; hit = 1'b0; addr = 32'd0; size = 2'b00;
    signExt = 1'b0; memOut = 8'd0;
    step();
    step();
    chk32("rst_memaddr", memAddress, 32'd0);
    chk1("rst_memreq", memReq, 1'b0);
    chk32("rst_loaddata", loadData, 32'd0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;

    run_load(32'h0000_0100, 2'b10, 1'b0, 0, 0, 0, 0);
    run_load(32'h0000_0080, 2'b00, 1'b1, 0, 0, 0, 0);
    run_load(32'h0000_0080, 2'b00, 1'b0, 0, 0, 0, 0);
    run_load(32'hFFFF_FFFF, 2'b01, 1'b0, 0, 0, 0, 0);
    run_load(32'hFFFF_FFFF, 2'b01, 1'b1, 0, 0, 0, 0);
    run_load(32'h0000_0100, 2'b10, 1'b0, 0, 0, 3, 0);
    run_load(32'h0000_01FE, 2'b11, 1'b1, 1, 0, 2, 0);
    run_load(32'h0000_0200, 2'b10, 1'b0, 0, TO, 0, 0);
    run_load(32'h0000_0300, 2'b01, 1'b1, TO - 1, TO - 1, 0, 0);

    // Abort a load mid-fetch with reset while req and hit are both high.
    req = 1'b1; addr = 32'h0000_0500; size = 2'b10; hit = 1'b0;
    step();
    req = 1'b0; hit = 1'b1; memOut = 8'h5A;
    step();
    step();
    reset = 1'b1; req = 1'b1;
    step();
    chk32("midrst_memaddr", memAddress, 32'd0);
    chk1("midrst_memreq", memReq, 1'b0);
    chk32("midrst_loaddata", loadData, 32'd0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_error", error, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    reset = 1'b0; req = 1'b0; hit = 1'b0;
    run_load(32'h0000_0400, 2'b10, 1'b0, 0, 1, 0, 0);

    key = 8'($urandom);
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < 4; j++) ms[j] = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) ms[$urandom_range(0, 3)] = TO;
      else if ($urandom_range(0, 5) == 0) ms[$urandom_range(0, 3)] = TO - 1;
      run_load($urandom, 2'($urandom), 1'($urandom), ms[0], ms[1], ms[2], ms[3]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
